pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Central sequencer for the 5-stage pipeline's enables and flushes. Merges three stall/flush sources into one prioritised set of stage-register controls:
- load-use stall from the hazard detector (load_use_stall),
- multi-cycle data-memory waits (request/ready handshake),
- branch/jump redirects resolved in EX.

Holds a small FSM for memory waits, with a timeout watchdog and a sticky error state.

Parameters:
MEM_TIMEOUT, 255, max cycles in DMEM_WAIT before entering ERROR (1..2^TO_W-1)
TO_W, 8, width of the wait/timeout counter
CNT_W, 32, width of each performance counter (optional feature only)

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
load_use_stall  input  1  load-use hazard from the hazard detector (ID instruction depends on EX load)
branch_taken  input  1  branch/jump redirect resolved in EX this cycle
mem_req  input  1  MEM-stage instruction is a load or store
mem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC write enable
if_id_en  output  1  IF/ID register write enable
id_ex_en  output  1  ID/EX register write enable
ex_mem_en  output  1  EX/MEM register write enable
if_id_flush  output  1  clear IF/ID to NOP
id_ex_flush  output  1  clear ID/EX to NOP (bubble)
mem_wb_bubble  output  1  write a NOP into MEM/WB
bus_error  output  1  sticky data-memory timeout flag
(with STALL_PERF_CNT_EN) load_use_cnt, dmem_wait_cnt, flush_cnt  output  CNT_W each  event counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, wait counter=0, bus_error=0.
  - All enables, flushes and mem_wb_bubble = 0 while rst_n is low.
  - Normal evaluation starts on the first clk edge after release.
- Outputs are combinational (Mealy) from the registered state and the current inputs, so a stall takes effect in the same cycle. Only state, wait counter, bus_error and the perf counters are registered.
- Decision in RUN, highest priority first:
  1. mem_req & !mem_ready:
     - Freeze: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1.
     - branch_taken and load_use_stall are ignored (the EX instruction is held and re-evaluated later).
     - Next state DMEM_WAIT, counter<=1.
  2. branch_taken:
     - All enables=1, if_id_flush=1, id_ex_flush=1.
     - A simultaneous load_use_stall is ignored (the dependent instruction is squashed).
  3. load_use_stall:
     - pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1.
     - Exactly one bubble per asserted cycle.
  4. Otherwise all enables=1, flushes=0, mem_wb_bubble=0.
- DMEM_WAIT:
  - mem_ready=0: full freeze as in item 1.
    - If counter==MEM_TIMEOUT: next state ERROR, bus_error<=1.
    - Else counter increments.
  - mem_ready=1: this cycle is decided by RUN items 2–4, with item 1 treated as satisfied. Next state RUN, counter<=0.
  - mem_req dropping while waiting is a protocol violation: treat it as completion and return to RUN.
- ERROR:
  - All enables=0, flushes=0, mem_wb_bubble=1, bus_error=1.
  - Left only by reset.
- Counter never wraps: the maximum value reached is MEM_TIMEOUT.
- A reset asserted mid-wait or in ERROR returns immediately to RUN with all registers cleared.
- A zero-latency memory (mem_ready high together with mem_req) never leaves RUN.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined:
  - Adds three saturating CNT_W counters, all cleared by reset and held at all-ones on saturation.
  - load_use_cnt: +1 per cycle where item 3 is the selected action.
  - dmem_wait_cnt: +1 per cycle with a freeze due to a memory wait, including the entering cycle.
  - flush_cnt: +1 per cycle where item 2 is selected.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg:
  - FSM state enum (RUN, DMEM_WAIT, ERROR), 2-bit encoding.
  - Default values for MEM_TIMEOUT and CNT_W.
  - A packed struct grouping the seven stage-control outputs, for reuse by the datapath top.
- One natural sub-module: stall_perf_counter (parameter CNT_W; inputs clk, rst_n, inc; output count, saturating). Instantiated three times under STALL_PERF_CNT_EN.

Test Plan:
- Load-use only: load_use_stall=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; next cycle all enables=1.
- Branch and load-use together: branch_taken=1 with load_use_stall=1 → pc_en=1, if_id_flush=1, id_ex_flush=1; load_use_cnt unchanged, flush_cnt +1.
- Memory wait, 3 cycles: mem_req=1, mem_ready low for 3 cycles then high → 3 freeze cycles with mem_wb_bubble=1, release on the 4th; dmem_wait_cnt=3; state back to RUN.
- Memory wait then branch: mem_ready rises in the same cycle as branch_taken=1 → that cycle flushes IF/ID and ID/EX with all enables 1.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 forever → bus_error=1 after the 5th freeze cycle; it stays set with enables 0 until rst_n pulses low.
- Async reset: assert rst_n low mid-DMEM_WAIT between clock edges → outputs go to reset values immediately; after release, state is RUN and the counter is 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, defaults and
// the stage-control bundle also consumed by the datapath top.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_ERROR     = 2'd2
  } ctrl_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 32;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_NORMAL = 7'b1111_000;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b0000_001;
  localparam stage_ctrl_t CTRL_BRANCH = 7'b1111_110;
  localparam stage_ctrl_t CTRL_LDUSE  = 7'b0011_010;
  localparam stage_ctrl_t CTRL_ERROR  = 7'b0000_001;

endpackage

// File: rtl/pipeline_stall_controller_perf.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module stall_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised stage enables/flushes from memory waits, branch redirects and load-use stalls.
// Define STALL_PERF_CNT_EN to add the load-use / dmem-wait / flush event counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_use_stall,
  input  logic branch_taken,
  input  logic mem_req,
  input  logic mem_ready,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic mem_wb_bubble,
  output logic bus_error
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] dmem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  ctrl_state_e     state;
  logic [TO_W-1:0] wait_cnt;
  stage_ctrl_t     ctrl;
  logic            mem_stall, sel_err, sel_frz, sel_br, sel_lu;

  // A dropped mem_req during DMEM_WAIT counts as completion, so RUN and
  // DMEM_WAIT share the same stall condition.
  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    sel_err   = (state == ST_ERROR);
    sel_frz   = ~sel_err & mem_stall;
    sel_br    = ~sel_err & ~sel_frz & branch_taken;
    sel_lu    = ~sel_err & ~sel_frz & ~branch_taken & load_use_stall;
    ctrl      = CTRL_NORMAL;
    if (!rst_n)       ctrl = '0;
    else if (sel_err) ctrl = CTRL_ERROR;
    else if (sel_frz) ctrl = CTRL_FREEZE;
    else if (sel_br)  ctrl = CTRL_BRANCH;
    else if (sel_lu)  ctrl = CTRL_LDUSE;
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_DMEM_WAIT;
            wait_cnt <= TO_W'(1);
          end
        end
        ST_DMEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt == TIMEOUT_V) begin
              state     <= ST_ERROR;
              bus_error <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        ST_ERROR: bus_error <= 1'b1;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  stall_perf_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk(clk), .rst_n(rst_n), .inc(sel_lu), .count(load_use_cnt)
  );
  stall_perf_counter #(.CNT_W(CNT_W)) u_dmem_wait_cnt (
    .clk(clk), .rst_n(rst_n), .inc(sel_frz), .count(dmem_wait_cnt)
  );
  stall_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(sel_br), .count(flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller (MEM_TIMEOUT=4) and a
// 2-bit stall_perf_counter saturation check.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use_stall, branch_taken, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, bus_error;
  logic       sat_inc;
  logic [1:0] sat_cnt;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] load_use_cnt, dmem_wait_cnt, flush_cnt;
`endif

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble, bus_error}
  localparam logic [7:0] V_RUN = 8'b1111_0000;
  localparam logic [7:0] V_LU  = 8'b0011_0100;
  localparam logic [7:0] V_BR  = 8'b1111_1100;
  localparam logic [7:0] V_FRZ = 8'b0000_0010;
  localparam logic [7:0] V_ERR = 8'b0000_0011;
  localparam logic [7:0] V_RST = 8'b0000_0000;

  logic [7:0] outs;
  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                 if_id_flush, id_ex_flush, mem_wb_bubble, bus_error};

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .bus_error(bus_error)
`ifdef STALL_PERF_CNT_EN
    , .load_use_cnt(load_use_cnt), .dmem_wait_cnt(dmem_wait_cnt), .flush_cnt(flush_cnt)
`endif
  );

  stall_perf_counter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .inc(sat_inc), .count(sat_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check the Mealy outputs before the next.
  task automatic apply(input string tag, input logic lu, input logic br,
                       input logic req, input logic rdy, input logic [7:0] exp);
    @(posedge clk);
    #1;
    load_use_stall = lu;
    branch_taken   = br;
    mem_req        = req;
    mem_ready      = rdy;
    #1 check_val(tag, 32'(outs), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sat_inc = 1'b0;
    load_use_stall = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    #3 check_val("reset_outs", 32'(outs), 32'(V_RST));
    #4 check_val("reset_outs_edge", 32'(outs), 32'(V_RST));
    load_use_stall = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #5 rst_n = 1'b1;
    sat_inc = 1'b1;

    apply("idle0",        0, 0, 0, 0, V_RUN);
    apply("load_use",     1, 0, 0, 0, V_LU);
    check_val("sat_mid", 32'(sat_cnt), 32'd2);
    apply("after_lu",     0, 0, 0, 0, V_RUN);
    apply("br_and_lu",    1, 1, 0, 0, V_BR);
    apply("wait3_a",      0, 0, 1, 0, V_FRZ);
    apply("wait3_b",      0, 0, 1, 0, V_FRZ);
    check_val("sat_top", 32'(sat_cnt), 32'd3);
    apply("wait3_c",      0, 0, 1, 0, V_FRZ);
    apply("wait3_rel",    0, 0, 1, 1, V_RUN);
    apply("idle1",        0, 0, 0, 0, V_RUN);
    check_val("sat_hold", 32'(sat_cnt), 32'd3);
`ifdef STALL_PERF_CNT_EN
    check_val("lu_cnt1",    load_use_cnt, 32'd1);
    check_val("flush_cnt1", flush_cnt, 32'd1);
    check_val("dmem_cnt1",  dmem_wait_cnt, 32'd3);
`endif
    apply("zero_lat",     0, 0, 1, 1, V_RUN);
    apply("zero_lat_nxt", 0, 0, 0, 0, V_RUN);
    apply("wb_wait",      0, 0, 1, 0, V_FRZ);
    apply("wb_rel_br",    0, 1, 1, 1, V_BR);
    apply("wb_after",     0, 0, 0, 0, V_RUN);
    apply("wl_wait_lu",   1, 0, 1, 0, V_FRZ);
    apply("wl_rel_lu",    1, 0, 1, 1, V_LU);
    apply("pv_wait",      0, 0, 1, 0, V_FRZ);
    apply("pv_drop",      0, 0, 0, 0, V_RUN);
    apply("pv_after",     0, 0, 0, 0, V_RUN);
`ifdef STALL_PERF_CNT_EN
    check_val("lu_cnt2",    load_use_cnt, 32'd2);
    check_val("flush_cnt2", flush_cnt, 32'd2);
    check_val("dmem_cnt2",  dmem_wait_cnt, 32'd6);
`endif
    apply("to_1",         0, 0, 1, 0, V_FRZ);
    apply("to_2",         0, 0, 1, 0, V_FRZ);
    apply("to_3",         0, 0, 1, 0, V_FRZ);
    apply("to_4",         0, 0, 1, 0, V_FRZ);
    apply("to_5",         0, 0, 1, 0, V_FRZ);
    apply("to_err",       0, 0, 1, 0, V_ERR);
    apply("err_sticky",   1, 1, 0, 1, V_ERR);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_val("rst_from_err", 32'(outs), 32'(V_RST));
`ifdef STALL_PERF_CNT_EN
    check_val("perf_cleared", dmem_wait_cnt, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    apply("post_rst1",    0, 0, 0, 0, V_RUN);
    apply("mid_wait_a",   0, 0, 1, 0, V_FRZ);
    apply("mid_wait_b",   0, 0, 1, 0, V_FRZ);
    #2 rst_n = 1'b0;
    #1 check_val("rst_mid_wait", 32'(outs), 32'(V_RST));
    @(negedge clk) rst_n = 1'b1;
    apply("post_rst2",    0, 0, 0, 0, V_RUN);
    apply("to2_1",        0, 0, 1, 0, V_FRZ);
    apply("to2_2",        0, 0, 1, 0, V_FRZ);
    apply("to2_3",        0, 0, 1, 0, V_FRZ);
    apply("to2_4",        0, 0, 1, 0, V_FRZ);
    apply("to2_5",        0, 0, 1, 0, V_FRZ);
    apply("to2_err",      0, 0, 1, 0, V_ERR);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
